if_stage: RTL and testbench

Instruction-fetch stage of the 5-stage pipeline: holds the program counter, drives the instruction-memory address, selects the next PC from sequential, branch and jump sources, and loads the IF/ID pipeline register consumed by the decode stage. It sits first in `top_pipe`, directly upstream of ID, and takes stall, flush and redirect requests from the hazard unit and the ID/EX stages. A halt detector freezes fetch on the HALT word.

---
 rtl/if_stage.sv | 134 +++++++++++++
 tb/tb_if_stage.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// if_stage: instruction-fetch stage. Holds the PC, drives the instruction-memory
// address and loads the IF/ID pipeline register. The optional HALT detector
// (freezes fetch on the all-ones word) is built only when IF_STAGE_HALT_EN is
// defined; otherwise 0xFFFFFFFF is an ordinary instruction and o_halted is 0.
module if_stage #(
   parameter int unsigned           NB_data  = 32,
   parameter int unsigned           NB_pc    = 32,
   parameter logic [NB_pc-1:0]      RESET_PC = '0
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 i_stall,
   input  logic                 i_flush,
   input  logic                 i_branch_taken,
   input  logic [NB_pc-1:0]     i_branch_target,
   input  logic                 i_jump,
   input  logic [NB_pc-1:0]     i_jump_target,
   output logic [NB_pc-1:0]     o_imem_addr,
   input  logic [NB_data-1:0]   i_imem_data,
   output logic [NB_data-1:0]   o_instr,
   output logic [NB_pc-1:0]     o_pc_plus4,
   output logic                 o_valid,
   output logic                 o_halted
);

   localparam logic [0:0]          RUN      = 1'b0;
   localparam logic [0:0]          HALTED   = 1'b1;
   localparam logic [NB_data-1:0]  NOP_WORD = '0;

   logic [0:0]          state;
   logic [0:0]          state_next;
   logic [NB_pc-1:0]    pc;
   logic [NB_pc-1:0]    pc_next;
   logic [NB_data-1:0]  instr_next;
   logic [NB_pc-1:0]    pc_plus4_next;
   logic                valid_next;

   logic [NB_pc-1:0]    pc_plus4_c;
   logic [NB_pc-1:0]    branch_tgt_c;
   logic [NB_pc-1:0]    jump_tgt_c;
   logic                redirect_c;
   logic                halt_word_c;
   logic                unused_tgt_lsbs;

   // Word-aligned targets; the low two target bits are deliberately dropped
   assign branch_tgt_c    = {i_branch_target[NB_pc-1:2], 2'b00};
   assign jump_tgt_c      = {i_jump_target[NB_pc-1:2], 2'b00};
   assign unused_tgt_lsbs = ^{i_branch_target[1:0], i_jump_target[1:0]};

   assign pc_plus4_c  = pc + NB_pc'(4);
   assign redirect_c  = i_branch_taken | i_jump;
   assign o_imem_addr = pc;

`ifdef IF_STAGE_HALT_EN
   localparam logic [NB_data-1:0] HALT_WORD = '1;
   assign halt_word_c = (i_imem_data == HALT_WORD);
   assign o_halted    = (state == HALTED);
`else
   assign halt_word_c = 1'b0;
   assign o_halted    = 1'b0;
`endif

   // State register, PC and IF/ID pipeline register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= RUN;
         pc         <= RESET_PC;
         o_instr    <= '0;
         o_pc_plus4 <= '0;
         o_valid    <= 1'b0;
      end else begin
         state      <= state_next;
         pc         <= pc_next;
         o_instr    <= instr_next;
         o_pc_plus4 <= pc_plus4_next;
         o_valid    <= valid_next;
      end
   end

   // Next-state, next-PC and IF/ID load selection
   always_comb begin
      state_next    = state;
      pc_next       = pc_plus4_c;
      instr_next    = o_instr;
      pc_plus4_next = o_pc_plus4;
      valid_next    = o_valid;

      // Next PC: branch (older) beats jump, then stall/halt hold, else sequential
      if (i_branch_taken) begin
         pc_next = branch_tgt_c;
      end else if (i_jump) begin
         pc_next = jump_tgt_c;
      end else if (i_stall) begin
         pc_next = pc;
      end else if (state == HALTED) begin
         pc_next = pc;
      end else if (halt_word_c && !i_flush) begin
         pc_next = pc;
      end

      // IF/ID: bubble on flush/redirect, hold on stall, bubble while halted
      if (i_flush || redirect_c) begin
         instr_next = NOP_WORD;
         valid_next = 1'b0;
      end else if (i_stall) begin
         instr_next    = o_instr;
         pc_plus4_next = o_pc_plus4;
         valid_next    = o_valid;
      end else if (state == HALTED) begin
         instr_next = NOP_WORD;
         valid_next = 1'b0;
      end else begin
         instr_next    = i_imem_data;
         pc_plus4_next = pc_plus4_c;
         valid_next    = 1'b1;
      end

      // HALT is entered only on a clean fetch; a redirect is the only way out
      case (state)
         RUN: begin
            if (halt_word_c && !i_stall && !i_flush && !redirect_c) begin
               state_next = HALTED;
            end
         end
         HALTED: begin
            if (redirect_c) begin
               state_next = RUN;
            end
         end
         default: state_next = RUN;
      endcase
   end

endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed fetch sequence with a scoreboard of expected IF outputs.
module tb_if_stage;

   logic        clk;
   logic        reset;
   logic        i_stall;
   logic        i_flush;
   logic        i_branch_taken;
   logic [31:0] i_branch_target;
   logic        i_jump;
   logic [31:0] i_jump_target;
   logic [31:0] o_imem_addr;
   logic [31:0] i_imem_data;
   logic [31:0] o_instr;
   logic [31:0] o_pc_plus4;
   logic        o_valid;
   logic        o_halted;

   logic [31:0] w_imem_addr;
   logic [31:0] w_instr;
   logic [31:0] w_pc_plus4;
   logic        w_valid;
   logic        w_halted;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic [31:0] pp4;
      logic        valid;
      logic        halted;
   } exp_t;

   exp_t sb[$];

   if_stage #(.NB_data(32), .NB_pc(32), .RESET_PC(32'h0)) dut (
      .clk(clk), .reset(reset), .i_stall(i_stall), .i_flush(i_flush),
      .i_branch_taken(i_branch_taken), .i_branch_target(i_branch_target),
      .i_jump(i_jump), .i_jump_target(i_jump_target),
      .o_imem_addr(o_imem_addr), .i_imem_data(i_imem_data),
      .o_instr(o_instr), .o_pc_plus4(o_pc_plus4), .o_valid(o_valid),
      .o_halted(o_halted)
   );

   // Second instance starting just below the wrap point
   if_stage #(.NB_data(32), .NB_pc(32), .RESET_PC(32'hFFFF_FFFC)) dut_w (
      .clk(clk), .reset(reset), .i_stall(1'b0), .i_flush(1'b0),
      .i_branch_taken(1'b0), .i_branch_target(32'h0),
      .i_jump(1'b0), .i_jump_target(32'h0),
      .o_imem_addr(w_imem_addr), .i_imem_data(32'h0),
      .o_instr(w_instr), .o_pc_plus4(w_pc_plus4), .o_valid(w_valid),
      .o_halted(w_halted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory model: word k holds k, except the HALT word at 0x14
   always_comb begin
      if (o_imem_addr == 32'h14) i_imem_data = 32'hFFFF_FFFF;
      else                       i_imem_data = {2'b00, o_imem_addr[31:2]};
   end

   function automatic exp_t mk(input logic [31:0] pc, input logic [31:0] instr,
                               input logic [31:0] pp4, input logic valid,
                               input logic halted);
      exp_t e;
      e.pc = pc; e.instr = instr; e.pp4 = pp4; e.valid = valid; e.halted = halted;
      return e;
   endfunction

   task automatic check(input string tag, input exp_t e);
      checks++;
      assert (o_imem_addr === e.pc) else begin
         errors++; $error("FAIL %s pc observed %h expected %h", tag, o_imem_addr, e.pc);
      end
      checks++;
      assert (o_instr === e.instr) else begin
         errors++; $error("FAIL %s instr observed %h expected %h", tag, o_instr, e.instr);
      end
      checks++;
      assert (o_pc_plus4 === e.pp4) else begin
         errors++; $error("FAIL %s pc_plus4 observed %h expected %h", tag, o_pc_plus4, e.pp4);
      end
      checks++;
      assert (o_valid === e.valid) else begin
         errors++; $error("FAIL %s valid observed %b expected %b", tag, o_valid, e.valid);
      end
      checks++;
      assert (o_halted === e.halted) else begin
         errors++; $error("FAIL %s halted observed %b expected %b", tag, o_halted, e.halted);
      end
   endtask

   task automatic step(input string tag, input logic st, input logic fl,
                       input logic br, input logic [31:0] bt,
                       input logic jp, input logic [31:0] jt, input exp_t e);
      exp_t got;
      i_stall = st; i_flush = fl;
      i_branch_taken = br; i_branch_target = bt;
      i_jump = jp; i_jump_target = jt;
      sb.push_back(e);
      @(posedge clk);
      #1;
      got = sb.pop_front();
      check(tag, got);
   endtask

   initial begin
      reset = 1'b0;
      i_stall = 1'b0; i_flush = 1'b0;
      i_branch_taken = 1'b0; i_branch_target = '0;
      i_jump = 1'b0; i_jump_target = '0;

      #10;
      check("reset", mk(32'h0, 32'h0, 32'h0, 1'b0, 1'b0));
      checks++;
      assert (w_imem_addr === 32'hFFFF_FFFC) else begin
         errors++; $error("FAIL wrap_reset pc observed %h expected %h", w_imem_addr, 32'hFFFF_FFFC);
      end
      #2 reset = 1'b1;

      // Sequential fetch
      step("seq0", 0, 0, 0, 0, 0, 0, mk(32'h04, 32'h0, 32'h04, 1, 0));
      checks++;
      assert (w_imem_addr === 32'h0) else begin
         errors++; $error("FAIL wrap pc observed %h expected %h", w_imem_addr, 32'h0);
      end
      step("seq1", 0, 0, 0, 0, 0, 0, mk(32'h08, 32'h1, 32'h08, 1, 0));

      // Three-cycle stall at PC=0x8
      step("stall0", 1, 0, 0, 0, 0, 0, mk(32'h08, 32'h1, 32'h08, 1, 0));
      step("stall1", 1, 0, 0, 0, 0, 0, mk(32'h08, 32'h1, 32'h08, 1, 0));
      step("stall2", 1, 0, 0, 0, 0, 0, mk(32'h08, 32'h1, 32'h08, 1, 0));
      step("resume", 0, 0, 0, 0, 0, 0, mk(32'h0C, 32'h2, 32'h0C, 1, 0));

      // Flush together with stall at PC=0xC
      step("flush_stall", 1, 1, 0, 0, 0, 0, mk(32'h0C, 32'h0, 32'h0C, 0, 0));
      step("seq3", 0, 0, 0, 0, 0, 0, mk(32'h10, 32'h3, 32'h10, 1, 0));
      step("seq4", 0, 0, 0, 0, 0, 0, mk(32'h14, 32'h4, 32'h14, 1, 0));

`ifdef IF_STAGE_HALT_EN
      step("halt_in", 0, 0, 0, 0, 0, 0, mk(32'h14, 32'hFFFF_FFFF, 32'h18, 1, 1));
      step("halt_bub", 0, 0, 0, 0, 0, 0, mk(32'h14, 32'h0, 32'h18, 0, 1));
      step("halt_stall", 1, 0, 0, 0, 0, 0, mk(32'h14, 32'h0, 32'h18, 0, 1));
      step("halt_exit", 0, 0, 1, 32'h2, 0, 0, mk(32'h00, 32'h0, 32'h18, 0, 0));
`else
      step("halt_word", 0, 0, 0, 0, 0, 0, mk(32'h18, 32'hFFFF_FFFF, 32'h18, 1, 0));
      step("past_halt", 0, 0, 0, 0, 0, 0, mk(32'h1C, 32'h6, 32'h1C, 1, 0));
      step("stall_b", 1, 0, 0, 0, 0, 0, mk(32'h1C, 32'h6, 32'h1C, 1, 0));
      step("branch0", 0, 0, 1, 32'h2, 0, 0, mk(32'h00, 32'h0, 32'h1C, 0, 0));
`endif
      step("restart", 0, 0, 0, 0, 0, 0, mk(32'h04, 32'h0, 32'h04, 1, 0));

      // Branch and jump together: branch wins
      step("br_jmp", 0, 0, 1, 32'h41, 1, 32'h80, mk(32'h40, 32'h0, 32'h04, 0, 0));
      step("br_tgt", 0, 0, 0, 0, 0, 0, mk(32'h44, 32'h10, 32'h44, 1, 0));

      // Jump alone, misaligned target
      step("jump", 0, 0, 0, 0, 1, 32'h103, mk(32'h100, 32'h0, 32'h44, 0, 0));
      step("jmp_tgt", 0, 0, 0, 0, 0, 0, mk(32'h104, 32'h40, 32'h104, 1, 0));

      // Reset asserted during a branch cycle, checked before the next edge
      i_branch_taken = 1'b1; i_branch_target = 32'h200;
      #1 reset = 1'b0;
      #1;
      check("mid_reset", mk(32'h0, 32'h0, 32'h0, 0, 0));
      checks++;
      assert (w_imem_addr === 32'hFFFF_FFFC) else begin
         errors++; $error("FAIL wrap_mid_reset pc observed %h expected %h", w_imem_addr, 32'hFFFF_FFFC);
      end
      i_branch_taken = 1'b0; i_branch_target = '0;
      reset = 1'b1;
      step("post_reset", 0, 0, 0, 0, 0, 0, mk(32'h04, 32'h0, 32'h04, 1, 0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
